// File: rtl/multicycle_control.sv
// Main control sequencer for the multi-cycle MIPS core: steps each instruction
// through fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic             ALUOp1,
  output logic             ALUOp0,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  state_t     state_q, state_d;
  logic       mem_read_c, mem_write_c, iord_c, ir_write_c, pc_write_c;
  logic       reg_write_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_source_c;
  logic       ext_zero_c, alu_op1_c, alu_op0_c, retire_c, halted_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      retire_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retire_count <= retire_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    ext_zero_c   = 1'b0;
    alu_op1_c    = 1'b0;
    alu_op0_c    = 1'b0;
    pc_source_c  = 2'b00;
    retire_c     = 1'b0;
    halted_c     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_RTYPE:                state_d = R_EXEC;
          OP_LW, OP_SW:            state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:          state_d = BRANCH;
          OP_J:                    state_d = JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_ORI, OP_SLTI, OP_LUI: state_d = I_EXEC;
          default:                 state_d = HALT;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire_c     = 1'b1;
        state_d      = FETCH;
      end
      MEM_WR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        retire_c    = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op1_c   = 1'b1;
        state_d     = R_WB;
      end
      R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op0_c   = 1'b1;
        pc_source_c = 2'b01;
        pc_write_c  = (opcode == OP_BNE) ? !zero : zero;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      I_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (opcode != OP_ADDI && opcode != OP_ADDIU) begin
          alu_op1_c = 1'b1;
          alu_op0_c = 1'b1;
        end
        ext_zero_c = (opcode == OP_ANDI) || (opcode == OP_ORI);
        state_d    = I_WB;
      end
      I_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset is asynchronous, so FETCH's strobes must be masked while rst is held.
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign iord       = iord_c       & ~rst;
  assign ir_write   = ir_write_c   & ~rst;
  assign pc_write   = pc_write_c   & ~rst;
  assign reg_write  = reg_write_c  & ~rst;
  assign reg_dst    = reg_dst_c    & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign alu_src_a  = alu_src_a_c  & ~rst;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
  assign ext_zero   = ext_zero_c   & ~rst;
  assign ALUOp1     = alu_op1_c    & ~rst;
  assign ALUOp0     = alu_op0_c    & ~rst;
  assign pc_source  = rst ? 2'b00 : pc_source_c;
  assign retire     = retire_c     & ~rst;
  assign halted     = halted_c     & ~rst;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state, control
// vector and retire count are queued, then popped and checked at negedge.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DEC  = 4'd1,  S_ADDR = 4'd2,
                         S_RD    = 4'd3,  S_MWB  = 4'd4,  S_WR   = 4'd5,
                         S_REX   = 4'd6,  S_RWB  = 4'd7,  S_BR   = 4'd8,
                         S_JMP   = 4'd9,  S_IEX  = 4'd10, S_IWB  = 4'd11,
                         S_HALT  = 4'd12;

  // Control vector layout, MSB first: mem_read mem_write iord ir_write pc_write
  // reg_write reg_dst mem_to_reg alu_src_a alu_src_b[1:0] ext_zero ALUOp1
  // ALUOp0 pc_source[1:0] retire halted
  localparam logic [17:0] MR      = 18'd1 << 17;
  localparam logic [17:0] MW      = 18'd1 << 16;
  localparam logic [17:0] IORD    = 18'd1 << 15;
  localparam logic [17:0] IRW     = 18'd1 << 14;
  localparam logic [17:0] PCW     = 18'd1 << 13;
  localparam logic [17:0] RW      = 18'd1 << 12;
  localparam logic [17:0] RD      = 18'd1 << 11;
  localparam logic [17:0] M2R     = 18'd1 << 10;
  localparam logic [17:0] SA      = 18'd1 << 9;
  localparam logic [17:0] SB_4    = 18'd1 << 7;
  localparam logic [17:0] SB_IMM  = 18'd2 << 7;
  localparam logic [17:0] SB_SH   = 18'd3 << 7;
  localparam logic [17:0] EZ      = 18'd1 << 6;
  localparam logic [17:0] OP_FN   = 18'd1 << 5;
  localparam logic [17:0] OP_SUB  = 18'd1 << 4;
  localparam logic [17:0] OP_OPC  = 18'd3 << 4;
  localparam logic [17:0] PCS_OUT = 18'd1 << 2;
  localparam logic [17:0] PCS_J   = 18'd2 << 2;
  localparam logic [17:0] RET     = 18'd1 << 1;
  localparam logic [17:0] HLT     = 18'd1;

  localparam logic [17:0] F_WAIT = MR | SB_4;
  localparam logic [17:0] F_RDY  = MR | IRW | PCW | SB_4;
  localparam logic [17:0] DEC    = SB_SH;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_BNE = 6'b000101, O_J = 6'b000010,
                         O_ORI = 6'b001101, O_ADDI = 6'b001000, O_LUI = 6'b001111,
                         O_BAD = 6'b111111;

  logic          clk = 1'b0;
  logic          rst, zero, mem_ready;
  logic [5:0]    opcode;
  logic          mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic          reg_dst, mem_to_reg, alu_src_a, ext_zero, ALUOp1, ALUOp0;
  logic [1:0]    alu_src_b, pc_source;
  logic [3:0]    state;
  logic          retire, halted;
  logic [CW-1:0] retire_count;
  logic [17:0]   obs;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .pc_source(pc_source),
    .state(state), .retire(retire), .retire_count(retire_count), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, ext_zero, ALUOp1, ALUOp0,
                pc_source, retire, halted};

  string         tag_q[$];
  logic [3:0]    st_q[$];
  logic [17:0]   ctl_q[$];
  logic [CW-1:0] cnt_q[$];
  logic [CW-1:0] model_cnt;
  int            checks = 0;
  int            failures = 0;

  task automatic push(input string tag, input logic [3:0] st, input logic [17:0] ctl);
    tag_q.push_back(tag);
    st_q.push_back(st);
    ctl_q.push_back(ctl);
    cnt_q.push_back(model_cnt);
    if ((ctl & RET) != 18'd0) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic check_now();
    string         t;
    logic [3:0]    es;
    logic [17:0]   ec;
    logic [CW-1:0] en;
    checks++;
    assert (st_q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end
    if (st_q.size() > 0) begin
      t = tag_q.pop_front();
      es = st_q.pop_front();
      ec = ctl_q.pop_front();
      en = cnt_q.pop_front();
      checks++;
      assert (state === es) else begin
        failures++;
        $error("FAIL %s state got=%0d exp=%0d", t, state, es);
      end
      checks++;
      assert (obs === ec) else begin
        failures++;
        $error("FAIL %s ctl got=%b exp=%b", t, obs, ec);
      end
      checks++;
      assert (retire_count === en) else begin
        failures++;
        $error("FAIL %s retire_count got=%0d exp=%0d", t, retire_count, en);
      end
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic z,
                      input logic rdy, input logic [3:0] st, input logic [17:0] ctl);
    opcode = op;
    zero = z;
    mem_ready = rdy;
    push(tag, st, ctl);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    model_cnt = '0;
    @(posedge clk);
    #1;
    step("rst_hold", O_R, 1'b1, 1'b1, S_FETCH, 18'd0);
    rst = 1'b0;

    // R-type, zero-wait
    step("r_fetch", O_R, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("r_dec",   O_R, 1'b0, 1'b1, S_DEC,   DEC);
    step("r_exec",  O_R, 1'b0, 1'b1, S_REX,   SA | OP_FN);
    step("r_wb",    O_R, 1'b0, 1'b1, S_RWB,   RW | RD | RET);

    // reset asserted in the middle of R_EXEC
    step("r2_fetch", O_R, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("r2_dec",   O_R, 1'b0, 1'b1, S_DEC,   DEC);
    push("r2_exec", S_REX, SA | OP_FN);
    @(negedge clk);
    check_now();
    #2;
    rst = 1'b1;
    model_cnt = '0;
    push("rst_mid", S_FETCH, 18'd0);
    #1;
    check_now();
    @(posedge clk);
    #1;
    step("rst_mid_hold", O_R, 1'b0, 1'b1, S_FETCH, 18'd0);
    rst = 1'b0;

    // lw with two wait cycles in MEM_RD; mem_ready high elsewhere is ignored
    step("lw_fetch", O_LW, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("lw_dec",   O_LW, 1'b0, 1'b1, S_DEC,   DEC);
    step("lw_addr",  O_LW, 1'b0, 1'b1, S_ADDR,  SA | SB_IMM);
    step("lw_rd0",   O_LW, 1'b0, 1'b0, S_RD,    MR | IORD);
    step("lw_rd1",   O_LW, 1'b0, 1'b0, S_RD,    MR | IORD);
    step("lw_rd2",   O_LW, 1'b0, 1'b1, S_RD,    MR | IORD);
    step("lw_wb",    O_LW, 1'b0, 1'b1, S_MWB,   RW | M2R | RET);

    // sw with one fetch wait and one write wait
    step("sw_fwait", O_SW, 1'b0, 1'b0, S_FETCH, F_WAIT);
    step("sw_fetch", O_SW, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("sw_dec",   O_SW, 1'b0, 1'b1, S_DEC,   DEC);
    step("sw_addr",  O_SW, 1'b0, 1'b0, S_ADDR,  SA | SB_IMM);
    step("sw_wr0",   O_SW, 1'b0, 1'b0, S_WR,    MW | IORD);
    step("sw_wr1",   O_SW, 1'b0, 1'b1, S_WR,    MW | IORD | RET);

    // branches
    step("beq_fetch", O_BEQ, 1'b1, 1'b1, S_FETCH, F_RDY);
    step("beq_dec",   O_BEQ, 1'b1, 1'b1, S_DEC,   DEC);
    step("beq_taken", O_BEQ, 1'b1, 1'b1, S_BR,    SA | OP_SUB | PCS_OUT | PCW | RET);
    step("bne_fetch", O_BNE, 1'b1, 1'b1, S_FETCH, F_RDY);
    step("bne_dec",   O_BNE, 1'b1, 1'b1, S_DEC,   DEC);
    step("bne_zero1", O_BNE, 1'b1, 1'b1, S_BR,    SA | OP_SUB | PCS_OUT | RET);
    step("bne2_fetch", O_BNE, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("bne2_dec",   O_BNE, 1'b0, 1'b1, S_DEC,   DEC);
    step("bne_zero0",  O_BNE, 1'b0, 1'b1, S_BR,    SA | OP_SUB | PCS_OUT | PCW | RET);

    // jump
    step("j_fetch", O_J, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("j_dec",   O_J, 1'b0, 1'b1, S_DEC,   DEC);
    step("j_jump",  O_J, 1'b0, 1'b1, S_JMP,   PCW | PCS_J | RET);

    // I-type variants
    step("ori_fetch", O_ORI, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("ori_dec",   O_ORI, 1'b0, 1'b1, S_DEC,   DEC);
    step("ori_exec",  O_ORI, 1'b0, 1'b1, S_IEX,   SA | SB_IMM | OP_OPC | EZ);
    step("ori_wb",    O_ORI, 1'b0, 1'b1, S_IWB,   RW | RET);
    step("addi_fetch", O_ADDI, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("addi_dec",   O_ADDI, 1'b0, 1'b1, S_DEC,   DEC);
    step("addi_exec",  O_ADDI, 1'b0, 1'b1, S_IEX,   SA | SB_IMM);
    step("addi_wb",    O_ADDI, 1'b0, 1'b1, S_IWB,   RW | RET);
    step("lui_fetch", O_LUI, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("lui_dec",   O_LUI, 1'b0, 1'b1, S_DEC,   DEC);
    step("lui_exec",  O_LUI, 1'b0, 1'b1, S_IEX,   SA | SB_IMM | OP_OPC);
    step("lui_wb",    O_LUI, 1'b0, 1'b1, S_IWB,   RW | RET);

    // illegal opcode halts until reset
    step("bad_fetch", O_BAD, 1'b0, 1'b1, S_FETCH, F_RDY);
    step("bad_dec",   O_BAD, 1'b0, 1'b1, S_DEC,   DEC);
    step("halt0",     O_BAD, 1'b0, 1'b1, S_HALT,  HLT);
    step("halt1",     O_R,   1'b1, 1'b1, S_HALT,  HLT);
    step("halt2",     O_J,   1'b0, 1'b0, S_HALT,  HLT);
    rst = 1'b1;
    model_cnt = '0;
    step("halt_rst", O_R, 1'b0, 1'b1, S_FETCH, 18'd0);
    rst = 1'b0;

    // counter wrap: 2^CW jumps bring the count back to zero
    for (int i = 0; i < 16; i++) begin
      step("wrap_fetch", O_J, 1'b0, 1'b1, S_FETCH, F_RDY);
      step("wrap_dec",   O_J, 1'b0, 1'b1, S_DEC,   DEC);
      if (i == 15) begin
        checks++;
        assert (retire_count === {CW{1'b1}}) else begin
          failures++;
          $error("FAIL cnt_all_ones got=%0d exp=%0d", retire_count, {CW{1'b1}});
        end
      end
      step("wrap_jump",  O_J, 1'b0, 1'b1, S_JMP,   PCW | PCS_J | RET);
    end
    checks++;
    assert (retire_count === '0) else begin
      failures++;
      $error("FAIL cnt_wrapped got=%0d exp=0", retire_count);
    end
    step("post_wrap_fetch", O_R, 1'b0, 1'b1, S_FETCH, F_RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
